// File: rtl/pipe_ctrl.sv
// Pipeline hazard and data-memory handshake controller: stalls, bubbles and
// flushes for a 5-stage pipeline, with a sticky timeout on memory accesses.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RA_W        = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_mem_read,
    input  logic            branch_taken,
    input  logic            mem_access,
    input  logic            dm_ack,
    output logic            dm_req,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            dm_timeout,
    output logic [7:0]      stall_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       load_use;

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (ex_rd == id_rt));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        dm_req       = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        case (state)
            RUN: begin
                dm_req = mem_access;
                if (mem_access && !dm_ack) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd0;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                dm_req = 1'b1;
                // An ack arriving on the last allowed cycle still wins over timeout.
                if (dm_ack) begin
                    state_nxt = RUN;
                end else begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
                    if (wait_cnt == WAIT_LAST) state_nxt = ERROR;
                    else                       wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            default: begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            end
        endcase
        // Outputs take their reset values immediately, independent of clk.
        if (reset) begin
            dm_req     = 1'b0;
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

    assign dm_timeout = (state == ERROR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= 8'd0;
        else if (!pc_en && state != ERROR && stall_cnt != 8'hFF)
            stall_cnt <= stall_cnt + 8'd1;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: hazards, memory wait, timeout,
// asynchronous reset and stall-counter saturation.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] id_rs, id_rt, ex_rd;
    logic       ex_mem_read, branch_taken, mem_access, dm_ack;
    logic       dm_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, dm_timeout;
    logic [7:0] stall_cnt;
    logic [7:0] ctl;

    int checks   = 0;
    int failures = 0;
    int exp_stall = 0;

    // {dm_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
    localparam logic [7:0] V_RESET  = 8'b0_00000_11;
    localparam logic [7:0] V_IDLE   = 8'b0_11111_00;
    localparam logic [7:0] V_LU     = 8'b0_00111_01;
    localparam logic [7:0] V_BR     = 8'b0_11111_11;
    localparam logic [7:0] V_MSTALL = 8'b1_00000_00;
    localparam logic [7:0] V_MACK   = 8'b1_11111_00;
    localparam logic [7:0] V_ERR    = 8'b0_00000_00;

    pipe_ctrl #(.MEM_TIMEOUT(15), .RA_W(3)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
        .mem_access(mem_access), .dm_ack(dm_ack), .dm_req(dm_req),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .dm_timeout(dm_timeout), .stall_cnt(stall_cnt)
    );

    assign ctl = {dm_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush};

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 3'd1; id_rt = 3'd2; ex_rd = 3'd5;
        ex_mem_read = 1'b0; branch_taken = 1'b0;
        mem_access = 1'b0; dm_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #2;
        checks++;
        if (ctl !== V_RESET) begin
            $display("[TB] FAIL reset_ctl got=%b want=%b", ctl, V_RESET); failures++;
        end
        checks++;
        if (stall_cnt !== 8'd0 || dm_timeout !== 1'b0) begin
            $display("[TB] FAIL reset_regs got stall=%0d tmo=%b want 0/0", stall_cnt, dm_timeout); failures++;
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_idle();
        @(negedge clk);
        checks++;
        if (ctl !== V_IDLE) begin
            $display("[TB] FAIL idle_ctl got=%b want=%b", ctl, V_IDLE); failures++;
        end
        next_cycle();
    endtask

    task automatic test_load_use_r0();
        ex_mem_read = 1'b1; ex_rd = 3'd0; id_rs = 3'd0; id_rt = 3'd0;
        @(negedge clk);
        checks++;
        if (ctl !== V_IDLE) begin
            $display("[TB] FAIL lu_r0_ctl got=%b want=%b", ctl, V_IDLE); failures++;
        end
        next_cycle();
        idle_inputs();
        checks++;
        if (stall_cnt !== 8'(exp_stall)) begin
            $display("[TB] FAIL lu_r0_stall got=%0d want=%0d", stall_cnt, exp_stall); failures++;
        end
    endtask

    task automatic test_load_use();
        // rs match, then rt match on a different register
        for (int k = 0; k < 2; k++) begin
            ex_mem_read = 1'b1;
            if (k == 0) begin ex_rd = 3'd3; id_rs = 3'd3; end
            else        begin ex_rd = 3'd6; id_rt = 3'd6; end
            @(negedge clk);
            checks++;
            if (ctl !== V_LU) begin
                $display("[TB] FAIL lu_ctl[%0d] got=%b want=%b", k, ctl, V_LU); failures++;
            end
            next_cycle();
            exp_stall++;
            idle_inputs();
            @(negedge clk);
            checks++;
            if (ctl !== V_IDLE || stall_cnt !== 8'(exp_stall)) begin
                $display("[TB] FAIL lu_after[%0d] got ctl=%b stall=%0d want ctl=%b stall=%0d",
                         k, ctl, stall_cnt, V_IDLE, exp_stall); failures++;
            end
            next_cycle();
        end
    endtask

    task automatic test_branch_load_use();
        branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3;
        @(negedge clk);
        checks++;
        if (ctl !== V_BR) begin
            $display("[TB] FAIL br_lu_ctl got=%b want=%b", ctl, V_BR); failures++;
        end
        next_cycle();
        idle_inputs();
        checks++;
        if (stall_cnt !== 8'(exp_stall)) begin
            $display("[TB] FAIL br_lu_stall got=%0d want=%0d", stall_cnt, exp_stall); failures++;
        end
    endtask

    task automatic test_mem_ack_same_cycle();
        mem_access = 1'b1; dm_ack = 1'b1; branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 8'b1_11111_11) begin
            $display("[TB] FAIL mem_ack0_ctl got=%b want=%b", ctl, 8'b1_11111_11); failures++;
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        mem_access = 1'b1; dm_ack = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            dm_ack = (c == 4);
            branch_taken = (c == 2);
            ex_mem_read = (c == 3); ex_rd = 3'd1;
            @(negedge clk);
            checks++;
            if (ctl !== ((c == 4) ? V_MACK : V_MSTALL)) begin
                $display("[TB] FAIL mem_wait_ctl[%0d] got=%b want=%b", c, ctl,
                         (c == 4) ? V_MACK : V_MSTALL); failures++;
            end
            next_cycle();
            if (c != 4) exp_stall++;
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (ctl !== V_IDLE || stall_cnt !== 8'(exp_stall)) begin
            $display("[TB] FAIL mem_wait_after got ctl=%b stall=%0d want ctl=%b stall=%0d",
                     ctl, stall_cnt, V_IDLE, exp_stall); failures++;
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        mem_access = 1'b1; dm_ack = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            checks++;
            if (ctl !== V_MSTALL || dm_timeout !== 1'b0) begin
                $display("[TB] FAIL tmo_wait[%0d] got ctl=%b tmo=%b want ctl=%b tmo=0",
                         c, ctl, dm_timeout, V_MSTALL); failures++;
            end
            next_cycle();
            exp_stall++;
        end
        for (int c = 0; c < 4; c++) begin
            dm_ack = (c >= 1); branch_taken = (c >= 2);
            @(negedge clk);
            checks++;
            if (ctl !== V_ERR || dm_timeout !== 1'b1 || stall_cnt !== 8'(exp_stall)) begin
                $display("[TB] FAIL tmo_error[%0d] got ctl=%b tmo=%b stall=%0d want ctl=%b tmo=1 stall=%0d",
                         c, ctl, dm_timeout, stall_cnt, V_ERR, exp_stall); failures++;
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_async(input string tag);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ctl !== V_RESET || dm_timeout !== 1'b0 || stall_cnt !== 8'd0) begin
            $display("[TB] FAIL %s_async got ctl=%b tmo=%b stall=%0d want ctl=%b tmo=0 stall=0",
                     tag, ctl, dm_timeout, stall_cnt, V_RESET); failures++;
        end
        #2;
        reset = 1'b0;
        exp_stall = 0;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (ctl !== V_IDLE || stall_cnt !== 8'd0) begin
            $display("[TB] FAIL %s_release got ctl=%b stall=%0d want ctl=%b stall=0",
                     tag, ctl, stall_cnt, V_IDLE); failures++;
        end
        next_cycle();
    endtask

    task automatic test_reset_in_mem_wait();
        mem_access = 1'b1; dm_ack = 1'b0;
        next_cycle();
        next_cycle();
        test_reset_async("rst_memwait");
        mem_access = 1'b1; dm_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== V_MACK) begin
            $display("[TB] FAIL rst_memwait_run got=%b want=%b", ctl, V_MACK); failures++;
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_saturation();
        ex_mem_read = 1'b1; ex_rd = 3'd4; id_rs = 3'd4;
        for (int c = 0; c < 260; c++) next_cycle();
        idle_inputs();
        checks++;
        if (stall_cnt !== 8'd255) begin
            $display("[TB] FAIL stall_sat got=%0d want=255", stall_cnt); failures++;
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load_use_r0();
        test_load_use();
        test_branch_load_use();
        test_mem_ack_same_cycle();
        test_mem_wait();
        test_timeout();
        test_reset_async("rst_error");
        test_reset_in_mem_wait();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
